// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle between the VGA sync/counter block and the pattern generator.
// Latency: n/a (wires only).
// Backpressure: none; the pixel stream is free-running at the pixel clock.
//
// master: sync side, drives frame_start/in_display/x/y and receives RGB + de_out.
// slave : pattern generator, the reverse direction.
interface vga_pattern_gen_if #(
  parameter int CNT_W   = 10,
  parameter int COLOR_W = 8
);
  logic               frame_start;
  logic               in_display;
  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic [COLOR_W-1:0] vga_r;
  logic [COLOR_W-1:0] vga_g;
  logic [COLOR_W-1:0] vga_b;
  logic               de_out;

  modport master (
    output frame_start, in_display, x, y,
    input  vga_r, vga_g, vga_b, de_out
  );

  modport slave (
    input  frame_start, in_display, x, y,
    output vga_r, vga_g, vga_b, de_out
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: RGB for the active area from sync-block pixel counters.
// Latency: exactly 2 clocks from x/y/in_display to RGB/de_out.
// Backpressure: none; accepts one pixel every clock.
//
// Ports: clk, rst_n (async active-low); pix (slave modport: frame_start, in_display,
// x, y in; vga_r/g/b, de_out out); mode_req[6:0] one-hot pattern request, latched on
// frame_start; box_freeze holds the bouncing box; mode_err flags a multi-bit request;
// box_x/box_y give the current box top-left corner.
// Optional feature: define CHECKER_EN to enable the 8x8 checkerboard on mode_req[6].
module vga_pattern_gen #(
  parameter int COLOR_W  = 8,
  parameter int CNT_W    = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_W    = 32,
  parameter int BOX_H    = 32,
  parameter int BOX_STEP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_pattern_gen_if.slave pix,
  input  logic [6:0]       mode_req,
  input  logic             box_freeze,
  output logic             mode_err,
  output logic [CNT_W-1:0] box_x,
  output logic [CNT_W-1:0] box_y
);

  localparam int PW = CNT_W + COLOR_W;
  localparam logic [PW-1:0]      CMAX   = PW'((1 << COLOR_W) - 1);
  localparam logic [CNT_W-1:0]   X_MAX  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0]   Y_MAX  = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]   X_LIM  = CNT_W'(H_ACTIVE - BOX_W);
  localparam logic [CNT_W-1:0]   Y_LIM  = CNT_W'(V_ACTIVE - BOX_H);
  localparam logic [COLOR_W-1:0] C_ONES = '1;

  localparam logic [6:0] M_GRAD  = 7'b0000001;
  localparam logic [6:0] M_RED   = 7'b0000010;
  localparam logic [6:0] M_GREEN = 7'b0000100;
  localparam logic [6:0] M_BLUE  = 7'b0001000;
  localparam logic [6:0] M_WHITE = 7'b0010000;
  localparam logic [6:0] M_BOX   = 7'b0100000;
`ifdef CHECKER_EN
  localparam logic [6:0] M_CHK   = 7'b1000000;
`endif

  // One axis of the bounce engine. Returns {moving_negative, position}.
  // "pos + STEP > LIM" is the same test as "pos + BOX + STEP > ACTIVE".
  function automatic logic [CNT_W:0] axis_next(input logic [CNT_W-1:0] pos,
                                               input logic neg,
                                               input logic [CNT_W-1:0] lim);
    logic [CNT_W:0] sum;
    logic [CNT_W:0] res;
    sum = {1'b0, pos} + (CNT_W+1)'(BOX_STEP);
    if (!neg) begin
      if (sum > {1'b0, lim}) res = {1'b1, lim};
      else                   res = {1'b0, sum[CNT_W-1:0]};
    end else begin
      if (pos < CNT_W'(BOX_STEP)) res = {1'b0, {CNT_W{1'b0}}};
      else                        res = {1'b1, pos - CNT_W'(BOX_STEP)};
    end
    axis_next = res;
  endfunction

  logic [6:0]         mode_in;
  logic [6:0]         mode_q, mode_d;
  logic               mode_err_q, mode_err_d;
  logic [CNT_W-1:0]   box_x_q, box_x_d, box_y_q, box_y_d;
  logic               dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [CNT_W-1:0]   s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic               s1_de_q, s1_de_d, s1_hit_q, s1_hit_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               de_out_q, de_out_d;
  logic [CNT_W-1:0]   xc, yc;
  logic [PW-1:0]      gx_prod, gy_prod;

`ifdef CHECKER_EN
  assign mode_in = mode_req;
`else
  // Checker request is dropped before latching so it never reaches the popcount.
  logic unused_chk_req;
  assign unused_chk_req = mode_req[6];
  assign mode_in = {1'b0, mode_req[5:0]};
`endif

  // Mode latch and box motion: both only move on frame_start.
  always_comb begin
    mode_d     = mode_q;
    mode_err_d = mode_err_q;
    box_x_d    = box_x_q;
    box_y_d    = box_y_q;
    dx_neg_d   = dx_neg_q;
    dy_neg_d   = dy_neg_q;
    if (pix.frame_start) begin
      mode_d     = mode_in;
      mode_err_d = ($countones(mode_in) > 1);
      if (!box_freeze) begin
        {dx_neg_d, box_x_d} = axis_next(box_x_q, dx_neg_q, X_LIM);
        {dy_neg_d, box_y_d} = axis_next(box_y_q, dy_neg_q, Y_LIM);
      end
    end
  end

  // Stage 1: box hit is computed from the pre-update position, so a pixel on
  // the frame_start cycle still sees the old box.
  always_comb begin
    s1_x_d   = pix.x;
    s1_y_d   = pix.y;
    s1_de_d  = pix.in_display;
    s1_hit_d = ({1'b0, pix.x} >= {1'b0, box_x_q}) &&
               ({1'b0, pix.x} <  ({1'b0, box_x_q} + (CNT_W+1)'(BOX_W))) &&
               ({1'b0, pix.y} >= {1'b0, box_y_q}) &&
               ({1'b0, pix.y} <  ({1'b0, box_y_q} + (CNT_W+1)'(BOX_H)));
  end

  // Stage 2: colour select on the latched mode. Zero or multi-bit modes fall
  // through to black via the default.
  always_comb begin
    xc       = (s1_x_q > X_MAX) ? X_MAX : s1_x_q;
    yc       = (s1_y_q > Y_MAX) ? Y_MAX : s1_y_q;
    gx_prod  = PW'(xc) * CMAX;
    gy_prod  = PW'(yc) * CMAX;
    r_d      = '0;
    g_d      = '0;
    b_d      = '0;
    de_out_d = s1_de_q;
    if (s1_de_q) begin
      case (mode_q)
        M_GRAD: begin
          r_d = COLOR_W'(gx_prod / PW'(H_ACTIVE - 1));
          b_d = COLOR_W'(gy_prod / PW'(V_ACTIVE - 1));
        end
        M_RED:   r_d = C_ONES;
        M_GREEN: g_d = C_ONES;
        M_BLUE:  b_d = C_ONES;
        M_WHITE: begin
          r_d = C_ONES;
          g_d = C_ONES;
          b_d = C_ONES;
        end
        M_BOX: begin
          if (s1_hit_q) begin
            r_d = C_ONES;
            b_d = C_ONES;
          end
        end
`ifdef CHECKER_EN
        M_CHK: begin
          if (s1_x_q[3] ^ s1_y_q[3]) begin
            r_d = C_ONES;
            g_d = C_ONES;
            b_d = C_ONES;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= '0;
      mode_err_q <= 1'b0;
      box_x_q    <= '0;
      box_y_q    <= '0;
      dx_neg_q   <= 1'b0;
      dy_neg_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_de_q    <= 1'b0;
      s1_hit_q   <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      de_out_q   <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      mode_err_q <= mode_err_d;
      box_x_q    <= box_x_d;
      box_y_q    <= box_y_d;
      dx_neg_q   <= dx_neg_d;
      dy_neg_q   <= dy_neg_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_de_q    <= s1_de_d;
      s1_hit_q   <= s1_hit_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      de_out_q   <= de_out_d;
    end
  end

  assign pix.vga_r  = r_q;
  assign pix.vga_g  = g_q;
  assign pix.vga_b  = b_q;
  assign pix.de_out = de_out_q;
  assign mode_err   = mode_err_q;
  assign box_x      = box_x_q;
  assign box_y      = box_y_q;

endmodule
